// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field definitions and FSM state encoding
// for the sequential subtractor.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  typedef enum logic [2:0] {IDLE, ALIGN, ARITH, NORM, DONE} state_t;

  // Operands are already flushed, so exp==0 always means an exact zero.
  function automatic logic [MANT_W-1:0] mant_of(input fp_t v);
    return (v.exp == '0) ? '0 : {1'b1, v.frac};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classification of one IEEE single operand.
module fp_classify
  import fp_pkg::*;
(
  input  fp_t  op,
  output logic is_zero,
  output logic is_inf,
  output logic is_nan,
  output logic is_denorm
);

  assign is_zero   = (op.exp == '0) && (op.frac == '0);
  assign is_denorm = (op.exp == '0) && (op.frac != '0);
  assign is_inf    = (op.exp == EXP_MAX) && (op.frac == '0);
  assign is_nan    = (op.exp == EXP_MAX) && (op.frac != '0);

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE single subtractor (diff = a - b), truncating, denormals
// flushed to zero, one operation in flight over valid/ready handshakes.
module fp_sub_seq
  import fp_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE   = 32'h7FC0_0000,
  parameter int unsigned ALIGN_LIMIT = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        busy
);

  state_t      state_reg, state_next;
  fp_t         a_reg, a_next, b_reg, b_next;
  logic        sign_reg, sign_next;
  logic [7:0]  exp_reg, exp_next;
  logic [23:0] mant_l_reg, mant_l_next, mant_s_reg, mant_s_next;
  logic        eff_add_reg, eff_add_next;
  logic [24:0] mant_reg, mant_next;
  logic [31:0] diff_reg, diff_next;

  fp_t  ops [2];
  fp_t  flushed [2];
  logic [1:0] zero_flag, inf_flag, nan_flag, denorm_flag;

  assign ops[0] = a;
  assign ops[1] = b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cls
    fp_classify u_cls (
      .op        (ops[gi]),
      .is_zero   (zero_flag[gi]),
      .is_inf    (inf_flag[gi]),
      .is_nan    (nan_flag[gi]),
      .is_denorm (denorm_flag[gi])
    );
    assign flushed[gi] = (zero_flag[gi] || denorm_flag[gi]) ?
                         {ops[gi].sign, 31'd0} : ops[gi];
  end

  // Alignment helpers: magnitude compare picks a on ties.
  logic        a_big;
  logic [7:0]  exp_gap;
  logic [23:0] mant_small, mant_aligned;
  logic [7:0]  exp_up, exp_dn;

  assign a_big        = {a_reg.exp, a_reg.frac} >= {b_reg.exp, b_reg.frac};
  assign exp_gap      = a_big ? (a_reg.exp - b_reg.exp) : (b_reg.exp - a_reg.exp);
  assign mant_small   = a_big ? mant_of(b_reg) : mant_of(a_reg);
  assign mant_aligned = (32'(exp_gap) >= ALIGN_LIMIT) ? 24'd0 : (mant_small >> exp_gap);
  assign exp_up       = exp_reg + 8'd1;
  assign exp_dn       = exp_reg - 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sign_reg    <= 1'b0;
      exp_reg     <= '0;
      mant_l_reg  <= '0;
      mant_s_reg  <= '0;
      eff_add_reg <= 1'b0;
      mant_reg    <= '0;
      diff_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      sign_reg    <= sign_next;
      exp_reg     <= exp_next;
      mant_l_reg  <= mant_l_next;
      mant_s_reg  <= mant_s_next;
      eff_add_reg <= eff_add_next;
      mant_reg    <= mant_next;
      diff_reg    <= diff_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    sign_next    = sign_reg;
    exp_next     = exp_reg;
    mant_l_next  = mant_l_reg;
    mant_s_next  = mant_s_reg;
    eff_add_next = eff_add_reg;
    mant_next    = mant_reg;
    diff_next    = diff_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = DONE;
          if (nan_flag != 2'b00) begin
            diff_next = NAN_VALUE;
          end else if (inf_flag == 2'b11 && a[31] == b[31]) begin
            diff_next = NAN_VALUE;
          end else if (inf_flag[0]) begin
            diff_next = a;
          end else if (inf_flag[1]) begin
            diff_next = {~b[31], b[30:0]};
          end else if (flushed[0].exp == '0 && flushed[1].exp == '0) begin
            diff_next = {a[31] & ~b[31], 31'd0};
          end else begin
            a_next     = flushed[0];
            b_next     = flushed[1];
            state_next = ALIGN;
          end
        end
      end
      ALIGN: begin
        // Subtraction is an add of b with its sign inverted.
        sign_next    = a_big ? a_reg.sign : ~b_reg.sign;
        exp_next     = a_big ? a_reg.exp : b_reg.exp;
        mant_l_next  = a_big ? mant_of(a_reg) : mant_of(b_reg);
        mant_s_next  = mant_aligned;
        eff_add_next = (a_reg.sign == ~b_reg.sign);
        state_next   = ARITH;
      end
      ARITH: begin
        mant_next  = eff_add_reg ? ({1'b0, mant_l_reg} + {1'b0, mant_s_reg})
                                 : ({1'b0, mant_l_reg} - {1'b0, mant_s_reg});
        state_next = NORM;
      end
      NORM: begin
        if (mant_reg[24]) begin
          mant_next = mant_reg >> 1;
          exp_next  = exp_up;
          if (exp_up == EXP_MAX) begin
            diff_next  = sign_reg ? NEG_INF : POS_INF;
            state_next = DONE;
          end
        end else if (mant_reg == '0) begin
          diff_next  = '0;
          state_next = DONE;
        end else if (mant_reg[23]) begin
          diff_next  = {sign_reg, exp_reg, mant_reg[22:0]};
          state_next = DONE;
        end else if (exp_dn == '0) begin
          diff_next  = {sign_reg, 31'd0};
          state_next = DONE;
        end else begin
          mant_next = mant_reg << 1;
          exp_next  = exp_dn;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;

endmodule
